// File: rtl/mux_pkg.sv
// Shared select encodings and select-code type for the mux leaf cell.
package mux_pkg;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_A = 2'b00;
    localparam sel_t SEL_B = 2'b01;
    localparam sel_t SEL_C = 2'b10;
    localparam sel_t SEL_D = 2'b11;

endpackage

// File: rtl/mux4_comb.sv
// Pure combinational 4:1 selector; an unknown select code yields an all-X result.
module mux4_comb
    import mux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  sel_t             sel,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = 'x;
        case (sel)
            SEL_A:   y = a;
            SEL_B:   y = b;
            SEL_C:   y = c;
            SEL_D:   y = d;
            // X/Z select propagates as X rather than falling back to an input
            default: y = 'x;
        endcase
    end

endmodule

// File: rtl/mux.sv
// Four-input mux with registered, valid-qualified copy of the selected input.
// Defining MUX_FAULT_EN adds an independent AND-OR path and a sticky fault flag.
module mux
    import mux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  sel_t             sel,
    output logic [WIDTH-1:0] out,
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out_q,
    output logic             out_valid
`ifdef MUX_FAULT_EN
    ,
    output logic             fault
`endif
);

    mux4_comb #(.WIDTH(WIDTH)) u_sel (
        .a   (a),
        .b   (b),
        .c   (c),
        .d   (d),
        .sel (sel),
        .y   (out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q     <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_q <= out;
            end
        end
    end

`ifdef MUX_FAULT_EN
    logic             dec_a;
    logic             dec_b;
    logic             dec_c;
    logic             dec_d;
    logic [WIDTH-1:0] red_out;

    // Gate-level decode kept separate from mux4_comb so the paths share no structure
    assign dec_a   = ~sel[1] & ~sel[0];
    assign dec_b   = ~sel[1] &  sel[0];
    assign dec_c   =  sel[1] & ~sel[0];
    assign dec_d   =  sel[1] &  sel[0];
    assign red_out = ({WIDTH{dec_a}} & a) | ({WIDTH{dec_b}} & b)
                   | ({WIDTH{dec_c}} & c) | ({WIDTH{dec_d}} & d);

    always_ff @(posedge clk) begin
        if (rst) begin
            fault <= 1'b0;
        end else if (|(out ^ red_out)) begin
            fault <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mux.sv
// Self-checking bench for mux at WIDTH=1 and WIDTH=8; covers the fault flag when MUX_FAULT_EN is defined.
module tb_mux;

    logic       clk;
    logic       clk_run;
    logic       rst;
    logic       in_valid;
    logic [1:0] sel;
    logic       a1, b1, c1, d1;
    logic [7:0] a8, b8, c8, d8;

    logic       out1, q1, v1;
    logic [7:0] out8, q8;
    logic       v8;
`ifdef MUX_FAULT_EN
    logic       fault1, fault8;
`endif

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic       m_q1;
    logic [7:0] m_q8;
    logic       m_v;
    logic       m_f1;
    bit         m_known  = 1'b0;
    bit         force_on = 1'b0;

    mux #(.WIDTH(1)) dut1 (
        .a(a1), .b(b1), .c(c1), .d(d1), .sel(sel), .out(out1),
        .clk(clk), .rst(rst), .in_valid(in_valid), .out_q(q1), .out_valid(v1)
`ifdef MUX_FAULT_EN
        , .fault(fault1)
`endif
    );

    mux #(.WIDTH(8)) dut8 (
        .a(a8), .b(b8), .c(c8), .d(d8), .sel(sel), .out(out8),
        .clk(clk), .rst(rst), .in_valid(in_valid), .out_q(q8), .out_valid(v8)
`ifdef MUX_FAULT_EN
        , .fault(fault8)
`endif
    );

    initial begin
        clk = 1'b0;
        wait (clk_run);
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] pick(input logic [1:0] s, input logic [7:0] v0,
                                        input logic [7:0] v1x, input logic [7:0] v2,
                                        input logic [7:0] v3);
        logic [7:0] t [4];
        t[0] = v0;
        t[1] = v1x;
        t[2] = v2;
        t[3] = v3;
        return t[s];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] s, input logic [3:0] n1,
                                 input logic [7:0] wa, input logic [7:0] wb,
                                 input logic [7:0] wc, input logic [7:0] wd,
                                 input logic v, input logic r);
        sel      = s;
        {a1, b1, c1, d1} = n1;
        a8       = wa;
        b8       = wb;
        c8       = wc;
        d8       = wd;
        in_valid = v;
        rst      = r;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Model: registered copy follows the selected input, reset has priority
    always @(posedge clk) begin
        if (rst) begin
            m_q1    = 1'b0;
            m_q8    = 8'h00;
            m_v     = 1'b0;
            m_f1    = 1'b0;
            m_known = 1'b1;
        end else begin
            if (force_on) m_f1 = 1'b1;
            m_v = in_valid;
            if (in_valid) begin
                m_q1 = pick(sel, {7'b0, a1}, {7'b0, b1}, {7'b0, c1}, {7'b0, d1});
                m_q8 = pick(sel, a8, b8, c8, d8);
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge
    always @(negedge clk) begin
        if (m_known) begin
            checkOutput("out1", {31'b0, out1},
                        {24'b0, pick(sel, {7'b0, a1}, {7'b0, b1}, {7'b0, c1}, {7'b0, d1})});
            checkOutput("out8", {24'b0, out8}, {24'b0, pick(sel, a8, b8, c8, d8)});
            checkOutput("out_q1", {31'b0, q1}, {31'b0, m_q1});
            checkOutput("out_q8", {24'b0, q8}, {24'b0, m_q8});
            checkOutput("out_valid1", {31'b0, v1}, {31'b0, m_v});
            checkOutput("out_valid8", {31'b0, v8}, {31'b0, m_v});
`ifdef MUX_FAULT_EN
            checkOutput("fault1", {31'b0, fault1}, {31'b0, m_f1});
            checkOutput("fault8", {31'b0, fault8}, 32'd0);
`endif
        end
    end

    initial begin
        logic       exp1 [4];
        logic [7:0] exp8 [4];
        exp1[0] = 1'b0; exp1[1] = 1'b1; exp1[2] = 1'b0; exp1[3] = 1'b1;
        exp8[0] = 8'h11; exp8[1] = 8'h22; exp8[2] = 8'h33; exp8[3] = 8'h44;
        clk_run = 1'b0;
        applyStimulus(2'b00, 4'b0101, 8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 1'b0);

        // Static pattern before any clock edge
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            #4;
            checkOutput("static_out1", {31'b0, out1}, {31'b0, exp1[i]});
            checkOutput("static_out8", {24'b0, out8}, {24'b0, exp8[i]});
            #1;
        end

        clk_run = 1'b1;
        applyStimulus(2'b00, 4'b0101, 8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 1'b1);
        step();
        checkOutput("reset_q8", {24'b0, q8}, 32'h00);
        checkOutput("reset_valid", {31'b0, v1}, 32'd0);

        // Registered capture then hold
        applyStimulus(2'b01, 4'b0101, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1, 1'b0);
        step();
        checkOutput("cap_q1", {31'b0, q1}, 32'd1);
        checkOutput("cap_valid", {31'b0, v1}, 32'd1);
        checkOutput("cap_q8", {24'b0, q8}, 32'h22);
        applyStimulus(2'b01, 4'b0101, 8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 1'b0);
        step();
        checkOutput("hold_valid", {31'b0, v1}, 32'd0);
        checkOutput("hold_q1", {31'b0, q1}, 32'd1);

        // Reset wins over simultaneous in_valid
        applyStimulus(2'b01, 4'b0101, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1, 1'b0);
        step();
        checkOutput("pre_rst_valid", {31'b0, v8}, 32'd1);
        applyStimulus(2'b01, 4'b0101, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1, 1'b1);
        step();
        checkOutput("rst_q1", {31'b0, q1}, 32'd0);
        checkOutput("rst_q8", {24'b0, q8}, 32'h00);
        checkOutput("rst_valid", {31'b0, v1}, 32'd0);
        checkOutput("rst_out1", {31'b0, out1}, 32'd1);
        checkOutput("rst_out8", {24'b0, out8}, 32'h22);

        // Wide data, sel=10
        applyStimulus(2'b10, 4'b0101, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1, 1'b0);
        #1;
        checkOutput("wide_out8", {24'b0, out8}, 32'h33);
        step();
        checkOutput("wide_q8", {24'b0, q8}, 32'h33);
        checkOutput("wide_q1", {31'b0, q1}, 32'd0);

        // All sel/data combinations, back-to-back captures with mixed valid
        for (int i = 0; i < 64; i++) begin
            applyStimulus(2'(i), 4'(i >> 2), 8'(i * 3 + 1), 8'(i * 5 + 7),
                          8'(i ^ 8'hA5), 8'(8'hF0 - i), (i % 3) != 0, 1'b0);
            step();
        end
        applyStimulus(2'b11, 4'b0001, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1, 1'b0);
        step();
        checkOutput("last_q8", {24'b0, q8}, 32'h44);
        checkOutput("last_q1", {31'b0, q1}, 32'd1);

`ifdef MUX_FAULT_EN
        checkOutput("nofault1", {31'b0, fault1}, 32'd0);
        // Force the redundant path for one cycle: out=0, redundant=1
        applyStimulus(2'b00, 4'b0111, 8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 1'b0);
        force dut1.red_out = 1'b1;
        force_on = 1'b1;
        step();
        release dut1.red_out;
        force_on = 1'b0;
        checkOutput("fault_set", {31'b0, fault1}, 32'd1);
        step();
        checkOutput("fault_held", {31'b0, fault1}, 32'd1);
        applyStimulus(2'b00, 4'b0111, 8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 1'b1);
        step();
        checkOutput("fault_clr", {31'b0, fault1}, 32'd0);
        applyStimulus(2'b00, 4'b0111, 8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 1'b0);
        step();
        checkOutput("fault_stay0", {31'b0, fault1}, 32'd0);
`endif

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
